// File: rtl/rominit_sched.sv
// rominit_sched: download sequencer between the HPS file-loader stream and the
// console ROM-init port. Decodes the loader index into boot/chr/cart selects,
// regenerates region-relative byte addresses, tracks which images are present
// and holds the console in reset until boot and chr are both loaded.
// Optional feature: define ROMINIT_BUNDLE_EN to treat index 0 as a combined
// boot+chr file split by IOCTL_ADDR (index 1 then becomes unknown).
module rominit_sched #(
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned AW       = 25
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          IOCTL_DOWNLOAD,
  input  logic [7:0]    IOCTL_INDEX,
  input  logic [AW-1:0] IOCTL_ADDR,
  input  logic [7:0]    IOCTL_DATA,
  input  logic          IOCTL_WR,
  output logic          IOCTL_WAIT,
  output logic          ROMINIT_SEL_BOOT,
  output logic          ROMINIT_SEL_CHR,
  output logic          ROMINIT_SEL_CART,
  output logic [AW-1:0] ROMINIT_ADDR,
  output logic [7:0]    ROMINIT_DATA,
  output logic          ROMINIT_VALID,
  output logic [2:0]    LOADED,
  output logic [AW-1:0] CART_SIZE,
  output logic          CPU_RESB
);

  localparam int unsigned HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StHold} state_e;

  state_e        r_state;
  logic [7:0]    r_index;
  logic [AW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_sel;
  logic [2:0]    r_loaded;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_cart_size;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_resb;

  logic          w_start;
  logic          w_sat;
  logic          w_accept;
  logic [AW-1:0] w_cnt_nxt;
  logic [2:0]    w_byte_sel;
  logic [AW-1:0] w_byte_addr;
  logic [2:0]    w_entry_sel;
  logic [2:0]    w_entry_clr;
  logic [2:0]    w_done_set;

`ifdef ROMINIT_BUNDLE_EN
  // Boot/chr bytes seen in the current combined-file session.
  logic [1:0]    r_seen;
`else
  logic          w_unused_addr;
  assign w_unused_addr = ^IOCTL_ADDR;
`endif

  // A new session may start from IDLE or abort a running HOLD.
  assign w_start   = IOCTL_DOWNLOAD && ((r_state == StIdle) || (r_state == StHold));
  assign w_sat     = &r_cnt;
  assign w_accept  = (r_state == StLoad) && IOCTL_WR && (|w_byte_sel) && !w_sat;
  // Includes a byte coincident with the DOWNLOAD fall.
  assign w_cnt_nxt = r_cnt + {{(AW-1){1'b0}}, w_accept};

  // Stall the loader while a session cannot accept bytes.
  assign IOCTL_WAIT = !RES && ((r_state == StFlush) ||
                               (((r_state == StIdle) || (r_state == StHold)) && IOCTL_DOWNLOAD));

  // Per-byte region decode and region-relative address.
  always_comb begin
    w_byte_sel  = 3'b000;
    w_byte_addr = r_cnt;
`ifdef ROMINIT_BUNDLE_EN
    if (r_index == 8'd0) begin
      if (IOCTL_ADDR < AW'(32'h1000)) begin
        w_byte_sel  = 3'b001;
        w_byte_addr = IOCTL_ADDR;
      end else if (IOCTL_ADDR < AW'(32'h1400)) begin
        w_byte_sel  = 3'b010;
        w_byte_addr = IOCTL_ADDR - AW'(32'h1000);
      end
    end else if (r_index == 8'd2) begin
      w_byte_sel = 3'b100;
    end
`else
    unique case (r_index)
      8'd0:    w_byte_sel = 3'b001;
      8'd1:    w_byte_sel = 3'b010;
      8'd2:    w_byte_sel = 3'b100;
      default: w_byte_sel = 3'b000;
    endcase
`endif
  end

  // Select shown on session entry and LOADED bits invalidated by the new image.
  always_comb begin
    w_entry_sel = 3'b000;
    w_entry_clr = 3'b000;
`ifdef ROMINIT_BUNDLE_EN
    if (IOCTL_INDEX == 8'd2) w_entry_sel = 3'b100;
    // The combined file replaces both boot and chr; selects follow each byte.
    w_entry_clr = (IOCTL_INDEX == 8'd0) ? 3'b011 : w_entry_sel;
`else
    unique case (IOCTL_INDEX)
      8'd0:    w_entry_sel = 3'b001;
      8'd1:    w_entry_sel = 3'b010;
      8'd2:    w_entry_sel = 3'b100;
      default: w_entry_sel = 3'b000;
    endcase
    w_entry_clr = w_entry_sel;
`endif
  end

  // LOADED bits to set when the session closes.
  always_comb begin
    w_done_set = 3'b000;
`ifdef ROMINIT_BUNDLE_EN
    if (r_index == 8'd0) begin
      w_done_set = {1'b0, r_seen | (w_accept ? w_byte_sel[1:0] : 2'b00)};
    end else if (w_cnt_nxt != '0) begin
      w_done_set = w_byte_sel;
    end
`else
    if (w_cnt_nxt != '0) w_done_set = w_byte_sel;
`endif
  end

  // Session FSM with registered byte path, flags and console reset.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state     <= StIdle;
      r_index     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_sel       <= '0;
      r_loaded    <= '0;
      r_addr      <= '0;
      r_cart_size <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_resb      <= 1'b0;
`ifdef ROMINIT_BUNDLE_EN
      r_seen      <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_start) begin
        r_state  <= StLoad;
        r_index  <= IOCTL_INDEX;
        r_cnt    <= '0;
        r_loaded <= r_loaded & ~w_entry_clr;
        r_sel    <= w_entry_sel;
        r_resb   <= 1'b0;
`ifdef ROMINIT_BUNDLE_EN
        r_seen   <= '0;
`endif
      end else begin
        unique case (r_state)
          StIdle: r_resb <= (r_loaded[1:0] == 2'b11);
          StLoad: begin
            if (w_accept) begin
              r_valid <= 1'b1;
              r_addr  <= w_byte_addr;
              r_data  <= IOCTL_DATA;
              r_sel   <= w_byte_sel;
              r_cnt   <= w_cnt_nxt;
`ifdef ROMINIT_BUNDLE_EN
              r_seen  <= r_seen | w_byte_sel[1:0];
`endif
            end
            if (!IOCTL_DOWNLOAD) begin
              r_state  <= StFlush;
              r_loaded <= r_loaded | w_done_set;
              if ((r_index == 8'd2) && (w_cnt_nxt != '0)) r_cart_size <= w_cnt_nxt;
            end
          end
          StFlush: begin
            r_state <= StHold;
            r_hold  <= HOLD_LOAD;
            r_sel   <= '0;
          end
          StHold: begin
            if (r_hold == '0) begin
              r_state <= StIdle;
              // Release in the first IDLE cycle.
              r_resb  <= (r_loaded[1:0] == 2'b11);
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign ROMINIT_SEL_BOOT = r_sel[0];
  assign ROMINIT_SEL_CHR  = r_sel[1];
  assign ROMINIT_SEL_CART = r_sel[2];
  assign ROMINIT_ADDR     = r_addr;
  assign ROMINIT_DATA     = r_data;
  assign ROMINIT_VALID    = r_valid;
  assign LOADED           = r_loaded;
  assign CART_SIZE        = r_cart_size;
  assign CPU_RESB         = r_resb;

endmodule

// File: tb/tb_rominit_sched.sv
// Bench for rominit_sched: randomized loader sessions against a byte
// scoreboard and image-presence model.
module tb_rominit_sched;
  localparam int unsigned HOLD_CYC = 16;
  localparam int unsigned AW       = 25;

  logic          CLK = 1'b0;
  logic          RES;
  logic          IOCTL_DOWNLOAD;
  logic [7:0]    IOCTL_INDEX;
  logic [AW-1:0] IOCTL_ADDR;
  logic [7:0]    IOCTL_DATA;
  logic          IOCTL_WR;
  logic          IOCTL_WAIT;
  logic          ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART;
  logic [AW-1:0] ROMINIT_ADDR;
  logic [7:0]    ROMINIT_DATA;
  logic          ROMINIT_VALID;
  logic [2:0]    LOADED;
  logic [AW-1:0] CART_SIZE;
  logic          CPU_RESB;
  logic [2:0]    sels;

  assign sels = {ROMINIT_SEL_CART, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};

  always #5 CLK = ~CLK;

  rominit_sched #(.HOLD_CYC(HOLD_CYC), .AW(AW)) dut (
    .CLK(CLK), .RES(RES),
    .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DATA(IOCTL_DATA), .IOCTL_WR(IOCTL_WR),
    .IOCTL_WAIT(IOCTL_WAIT),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID),
    .LOADED(LOADED), .CART_SIZE(CART_SIZE), .CPU_RESB(CPU_RESB)
  );

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [2:0]    m_loaded = 3'b000;
  logic [AW-1:0] m_cart   = '0;
  bit            no_sel   = 1'b0;
  logic [7:0]    idx_tab [4] = '{8'd0, 8'd1, 8'd2, 8'd5};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Region that a loader byte belongs to (none = dropped).
  function automatic logic [2:0] byte_sel(input logic [7:0] idx, input logic [AW-1:0] a);
`ifdef ROMINIT_BUNDLE_EN
    if (idx == 8'd0) return (a < AW'(32'h1000)) ? 3'b001 : ((a < AW'(32'h1400)) ? 3'b010 : 3'b000);
    return (idx == 8'd2) ? 3'b100 : 3'b000;
`else
    if (idx == 8'd0) return 3'b001;
    if (idx == 8'd1) return 3'b010;
    if (idx == 8'd2) return 3'b100;
    return 3'b000;
`endif
  endfunction

  function automatic logic [2:0] entry_sel(input logic [7:0] idx);
`ifdef ROMINIT_BUNDLE_EN
    return (idx == 8'd2) ? 3'b100 : 3'b000;
`else
    return byte_sel(idx, '0);
`endif
  endfunction

  function automatic logic [2:0] clear_mask(input logic [7:0] idx);
`ifdef ROMINIT_BUNDLE_EN
    if (idx == 8'd0) return 3'b011;
`endif
    return entry_sel(idx);
  endfunction

  // Byte scoreboard and select monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RES) begin
      if (no_sel) check_eq("no_sel", 32'(sels), 32'd0);
      if (ROMINIT_VALID) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(ROMINIT_VALID), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("byte_sel", 32'(sels), 32'(mon_e.sel));
          check_eq("byte_addr", 32'(ROMINIT_ADDR), 32'(mon_e.addr));
          check_eq("byte_data", 32'(ROMINIT_DATA), 32'(mon_e.data));
        end
      end
    end
  end

  // One loader session; returns with DOWNLOAD low, driven just after an edge.
  task automatic session(input logic [7:0] idx, input int n, input bit gaps,
                         input bit fall_with_last, input logic [AW-1:0] base,
                         input int exp_wait);
    int            waited;
    int            sent;
    int            cnt;
    logic [2:0]    set_mask;
    logic [2:0]    s;
    logic [AW-1:0] a;
    exp_t          t;
    IOCTL_INDEX    = idx;
    IOCTL_DOWNLOAD = 1'b1;
    #1;
    check_eq("wait_on_start", 32'(IOCTL_WAIT), 32'd1);
    waited = 0;
    do begin
      @(posedge CLK); #1;
      waited++;
    end while (IOCTL_WAIT && waited < 50);
    check_eq("wait_cycles", waited, exp_wait);
    check_eq("sel_on_entry", 32'(sels), 32'(entry_sel(idx)));
    check_eq("resb_in_load", 32'(CPU_RESB), 32'd0);
    m_loaded = m_loaded & ~clear_mask(idx);
    set_mask = 3'b000;
    cnt      = 0;
    sent     = 0;
    while (sent < n) begin
      if (!gaps || $urandom_range(0, 3) != 0) begin
        a          = base + AW'(sent);
        IOCTL_ADDR = a;
        IOCTL_DATA = 8'($urandom);
        IOCTL_WR   = 1'b1;
        s          = byte_sel(idx, a);
        if (s != 3'b000) begin
          t.sel  = s;
          t.data = IOCTL_DATA;
          t.addr = AW'(cnt);
`ifdef ROMINIT_BUNDLE_EN
          if (idx == 8'd0) t.addr = (s == 3'b001) ? a : a - AW'(32'h1000);
`endif
          exp_q.push_back(t);
          set_mask = set_mask | s;
          cnt++;
        end
        sent++;
        if (sent == n && fall_with_last) IOCTL_DOWNLOAD = 1'b0;
      end else begin
        IOCTL_WR = 1'b0;
      end
      if (sent == n / 2 && n > 100) check_eq("resb_mid_load", 32'(CPU_RESB), 32'd0);
      @(posedge CLK); #1;
    end
    IOCTL_WR       = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    m_loaded = m_loaded | set_mask;
    if (idx == 8'd2 && cnt > 0) m_cart = AW'(cnt);
  endtask

  task automatic settle();
    repeat (HOLD_CYC + 4) @(posedge CLK);
    #1;
  endtask

  task automatic post_check(input string tag);
    check_eq({tag, "_loaded"}, 32'(LOADED), 32'(m_loaded));
    check_eq({tag, "_cart_size"}, 32'(CART_SIZE), 32'(m_cart));
    check_eq({tag, "_resb"}, 32'(CPU_RESB), 32'(m_loaded[1:0] == 2'b11));
    check_eq({tag, "_wait"}, 32'(IOCTL_WAIT), 32'd0);
  endtask

  initial begin
    int   k;
    exp_t t;
    RES            = 1'b1;
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_INDEX    = '0;
    IOCTL_ADDR     = '0;
    IOCTL_DATA     = '0;
    IOCTL_WR       = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_sel", 32'(sels), 32'd0);
    check_eq("rst_valid", 32'(ROMINIT_VALID), 32'd0);
    check_eq("rst_wait", 32'(IOCTL_WAIT), 32'd0);
    check_eq("rst_addr", 32'(ROMINIT_ADDR), 32'd0);
    check_eq("rst_data", 32'(ROMINIT_DATA), 32'd0);
    check_eq("rst_loaded", 32'(LOADED), 32'd0);
    check_eq("rst_cart", 32'(CART_SIZE), 32'd0);
    check_eq("rst_resb", 32'(CPU_RESB), 32'd0);
    RES = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    post_check("idle_after_rst");

    // Boot only, WR every cycle, last byte coincident with the DOWNLOAD fall.
    session(8'd0, 4096, 1'b0, 1'b1, '0, 1);
    settle();
    post_check("boot");

    // Chr image; release timing measured from the DOWNLOAD fall.
    session(8'd1, 1024, 1'b0, 1'b0, '0, 1);
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (!CPU_RESB && k < 40);
    if (m_loaded[1:0] == 2'b11) check_eq("release_cycles", k, HOLD_CYC + 2);
    else check_eq("resb_stays_low", 32'(CPU_RESB), 32'd0);
    settle();
    post_check("chr");

    // Zero-length cart session.
    session(8'd2, 0, 1'b0, 1'b0, '0, 1);
    settle();
    post_check("cart_empty");

    // Cart with random gaps between bytes.
    session(8'd2, 32'h8000, 1'b1, 1'b0, '0, 1);
    settle();
    post_check("cart");

    // Unknown index: nothing selected, nothing written.
    no_sel = 1'b1;
    session(8'd7, 20, 1'b1, 1'b0, '0, 1);
    settle();
    no_sel = 1'b0;
    post_check("unknown");

    // Back-to-back: DOWNLOAD re-rises one cycle after the fall.
    session(8'd1, 50, 1'b1, 1'b0, '0, 1);
    @(posedge CLK); #1;
    session(8'd0, 30, 1'b0, 1'b0, '0, 2);
    settle();
    post_check("b2b");

`ifdef ROMINIT_BUNDLE_EN
    // Combined file straddling the boot/chr boundary.
    session(8'd0, 4, 1'b0, 1'b0, AW'(32'h0FFE), 1);
    settle();
    post_check("bundle_split");
`endif

    // Random sessions.
    for (int i = 0; i < 8; i++) begin
      session(idx_tab[$urandom_range(0, 3)], int'($urandom_range(0, 40)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 1);
      settle();
      post_check("rand");
    end

    // Reset in the middle of a cart download.
    IOCTL_INDEX    = 8'd2;
    IOCTL_DOWNLOAD = 1'b1;
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (IOCTL_WAIT && k < 50);
    for (int i = 0; i < 100; i++) begin
      IOCTL_WR   = 1'b1;
      IOCTL_DATA = 8'($urandom);
      t.sel  = 3'b100;
      t.addr = AW'(i);
      t.data = IOCTL_DATA;
      exp_q.push_back(t);
      @(posedge CLK); #1;
    end
    IOCTL_WR = 1'b0;
    RES      = 1'b1;
    exp_q.delete();
    #1;
    m_loaded = 3'b000;
    m_cart   = '0;
    check_eq("midrst_sel", 32'(sels), 32'd0);
    check_eq("midrst_valid", 32'(ROMINIT_VALID), 32'd0);
    check_eq("midrst_wait", 32'(IOCTL_WAIT), 32'd0);
    check_eq("midrst_addr", 32'(ROMINIT_ADDR), 32'd0);
    check_eq("midrst_data", 32'(ROMINIT_DATA), 32'd0);
    check_eq("midrst_loaded", 32'(LOADED), 32'd0);
    check_eq("midrst_cart", 32'(CART_SIZE), 32'd0);
    check_eq("midrst_resb", 32'(CPU_RESB), 32'd0);
    IOCTL_DOWNLOAD = 1'b0;
    @(posedge CLK); #1;
    RES = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    post_check("after_rst");

    check_eq("bytes_lost", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
